// File: rtl/upper_digit_scheduler.sv
// ---------------------------------------------------------------------------
// upper_digit_scheduler
//
// Sequencer wrapped around a non-pipelined upper-product multiplier
// (multiplier_upper_2_bit). It takes operand pairs over a valid/ready
// handshake and issues one mul_en pulse per pair. It then waits out the
// multiplier's fixed latency and captures the 2-bit result digit. Digits are
// packed MSB-first into a word, and the word is presented downstream over
// valid/ready.
//
// Only one multiplication is ever in flight. The multiplier keeps an internal
// latency counter, and a second start pulse issued early would corrupt it.
//
// Ports
//   clk         in   rising-edge clock
//   rst         in   asynchronous active-high reset
//   in_valid    in   operand pair valid
//   in_ready    out  scheduler can take a pair (IDLE only, low during reset)
//   in_a, in_b  in   operands, MUL_SIZE bits each
//   in_last     in   this pair closes the current word
//   mul_en      out  one-cycle start pulse to the multiplier
//   mul_a/b     out  held operands to the multiplier
//   mul_res     in   2-bit upper-product digit from the multiplier
//   out_valid   out  packed word valid
//   out_ready   in   downstream accepts the word
//   out_digits  out  packed digits, first digit in the top two bits
//   out_len     out  number of valid digits in the word (1..NUM_DIGITS)
// ---------------------------------------------------------------------------
module upper_digit_scheduler #(
    parameter int MUL_SIZE   = 80,
    parameter int NUM_DIGITS = 8,
    parameter int MUL_LAT    = 3,
    parameter int LEN_W      = $clog2(NUM_DIGITS + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [MUL_SIZE-1:0]     in_a,
    input  logic [MUL_SIZE-1:0]     in_b,
    input  logic                    in_last,
    output logic                    mul_en,
    output logic [MUL_SIZE-1:0]     mul_a,
    output logic [MUL_SIZE-1:0]     mul_b,
    input  logic [1:0]              mul_res,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*NUM_DIGITS-1:0] out_digits,
    output logic [LEN_W-1:0]        out_len
);

    // The wait counter only has to count 0..MUL_LAT-1.
    localparam int CNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_LAT - 1);
    localparam logic [LEN_W-1:0] IDX_FULL = LEN_W'(NUM_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_OUT   = 2'd3
    } state_t;

    state_t                  r_state;
    logic [MUL_SIZE-1:0]     r_op_a;
    logic [MUL_SIZE-1:0]     r_op_b;
    logic                    r_last;
    logic [CNT_W-1:0]        r_cnt;
    logic [LEN_W-1:0]        r_idx;
    logic [2*NUM_DIGITS-1:0] r_digits;
    logic [LEN_W-1:0]        r_len;
    logic                    r_mul_en;
    logic                    r_out_valid;

    logic                    w_accept;
    logic [LEN_W-1:0]        w_idx_next;

    // in_ready is a plain decode of the state register. It is gated by rst so
    // that it drops in the same instant the reset is applied.
    assign in_ready   = (r_state == S_IDLE) && !rst;
    assign w_accept   = in_valid && in_ready;
    assign w_idx_next = r_idx + LEN_W'(1);

    assign mul_en     = r_mul_en;
    assign mul_a      = r_op_a;
    assign mul_b      = r_op_b;
    assign out_valid  = r_out_valid;
    assign out_digits = r_digits;
    assign out_len    = r_len;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_last      <= 1'b0;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_digits    <= '0;
            r_len       <= '0;
            r_mul_en    <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_op_a   <= in_a;
                        r_op_b   <= in_b;
                        r_last   <= in_last;
                        // Registered start pulse: it is high exactly while in ISSUE.
                        r_mul_en <= 1'b1;
                        r_state  <= S_ISSUE;
                    end
                end

                S_ISSUE: begin
                    r_mul_en <= 1'b0;
                    r_cnt    <= '0;
                    r_state  <= S_WAIT;
                end

                S_WAIT: begin
                    if (r_cnt == CNT_LAST) begin
                        // This edge is the MUL_LAT-th edge after the mul_en edge.
                        // It is the only edge at which mul_res holds the digit.
                        for (int k = 0; k < NUM_DIGITS; k++) begin
                            if (r_idx == LEN_W'(k)) begin
                                r_digits[2*NUM_DIGITS-1-2*k -: 2] <= mul_res;
                            end
                        end
                        r_idx <= w_idx_next;
                        if (r_last || (w_idx_next == IDX_FULL)) begin
                            r_len       <= w_idx_next;
                            r_out_valid <= 1'b1;
                            r_state     <= S_OUT;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end

                S_OUT: begin
                    // The word and its length stay frozen until the downstream
                    // side accepts it. The buffer is cleared on acceptance, so
                    // the unused low digits of the next short word read as zero.
                    if (out_ready) begin
                        r_digits    <= '0;
                        r_len       <= '0;
                        r_idx       <= '0;
                        r_out_valid <= 1'b0;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_upper_digit_scheduler.sv
// ---------------------------------------------------------------------------
// Testbench for upper_digit_scheduler.
// It contains a behavioural multiplier that drives the true upper digit only
// in the capture cycle and drives 00 at all other times. A word-level
// reference model predicts each packed word from the accepted operand pairs.
// Directed tests cover the word, backpressure and reset cases, and a
// randomized phase follows them.
// ---------------------------------------------------------------------------
module tb_upper_digit_scheduler;

    localparam int MUL_SIZE   = 80;
    localparam int NUM_DIGITS = 8;
    localparam int MUL_LAT    = 3;
    localparam int LEN_W      = 4;
    localparam int RADIX      = 78;

    logic                    clk;
    logic                    rst;
    logic                    in_valid;
    logic                    in_ready;
    logic [MUL_SIZE-1:0]     in_a;
    logic [MUL_SIZE-1:0]     in_b;
    logic                    in_last;
    logic                    mul_en;
    logic [MUL_SIZE-1:0]     mul_a;
    logic [MUL_SIZE-1:0]     mul_b;
    logic [1:0]              mul_res;
    logic                    out_valid;
    logic                    out_ready;
    logic [2*NUM_DIGITS-1:0] out_digits;
    logic [LEN_W-1:0]        out_len;

    upper_digit_scheduler #(
        .MUL_SIZE  (MUL_SIZE),
        .NUM_DIGITS(NUM_DIGITS),
        .MUL_LAT   (MUL_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_last   (in_last),
        .mul_en    (mul_en),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_res   (mul_res),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_digits(out_digits),
        .out_len   (out_len)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Bits 2*RADIX+3 : 2*RADIX+2 of the full-width product.
    function automatic logic [1:0] ref_digit(input logic [MUL_SIZE-1:0] a, input logic [MUL_SIZE-1:0] b);
        logic [2*MUL_SIZE-1:0] p;
        p = {{MUL_SIZE{1'b0}}, a} * {{MUL_SIZE{1'b0}}, b};
        return p[2*RADIX+3 -: 2];
    endfunction

    function automatic logic [MUL_SIZE-1:0] rand_op();
        return {16'($urandom), $urandom, $urandom};
    endfunction

    // Behavioural multiplier: the result is visible only in the cycle before
    // the MUL_LAT-th edge after the mul_en edge.
    logic [1:0] m_val = 2'b00;
    int         m_cnt = 0;
    always @(posedge clk) begin
        if (mul_en) begin
            m_val <= ref_digit(mul_a, mul_b);
            m_cnt <= 1;
        end else if (m_cnt == MUL_LAT) begin
            m_cnt <= 0;
        end else if (m_cnt != 0) begin
            m_cnt <= m_cnt + 1;
        end
    end
    assign mul_res = (m_cnt == MUL_LAT) ? m_val : 2'b00;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference model and monitor state.
    logic [15:0] cur_d = '0;
    int          cur_n = 0;
    logic [19:0] exp_q[$];
    int          last_acc_cyc = 0;
    bit          spacing_mode = 0;
    bit          prev_mul_en  = 0;
    bit          inflight     = 0;
    bit          hold_pend    = 0;
    logic [15:0] hold_d = '0;
    logic [3:0]  hold_l = '0;
    int          n_acc = 0;
    int          n_mul = 0;
    bit          rnd_or = 0;

    always @(negedge clk) begin
        logic [19:0] e;
        logic [1:0]  d;
        if (rst) begin
            cur_n       = 0;
            cur_d       = '0;
            inflight    = 0;
            hold_pend   = 0;
            prev_mul_en = 0;
            exp_q.delete();
        end else begin
            if (mul_en) begin
                check_val("mul_en_single", 64'(prev_mul_en), 64'(0));
                check_val("mul_en_inflight", 64'(inflight), 64'(0));
                check_val("rdy_low_issue", 64'(in_ready), 64'(0));
                inflight = 1;
                n_mul++;
            end
            prev_mul_en = mul_en;
            if (m_cnt == MUL_LAT) inflight = 0;

            if (hold_pend) begin
                check_val("hold_valid", 64'(out_valid), 64'(1));
                check_val("hold_digits", 64'(out_digits), 64'(hold_d));
                check_val("hold_len", 64'(out_len), 64'(hold_l));
            end
            hold_pend = 0;

            if (out_valid) begin
                check_val("rdy_low_out", 64'(in_ready), 64'(0));
                if (out_ready) begin
                    if (exp_q.size() == 0) begin
                        check_val("word_unexpected", 64'(out_digits), 64'hDEAD_0000_0000_0000);
                    end else begin
                        e = exp_q.pop_front();
                        check_val("word_digits", 64'(out_digits), 64'(e[15:0]));
                        check_val("word_len", 64'(out_len), 64'(e[19:16]));
                    end
                end else begin
                    hold_pend = 1;
                    hold_d    = out_digits;
                    hold_l    = out_len;
                end
            end

            if (in_valid && in_ready) begin
                if (spacing_mode && cur_n > 0)
                    check_val("accept_gap", 64'(cyc - last_acc_cyc), 64'(MUL_LAT + 2));
                last_acc_cyc = cyc;
                d     = ref_digit(in_a, in_b);
                cur_d = cur_d | (16'(d) << (2*NUM_DIGITS - 2 - 2*cur_n));
                cur_n++;
                n_acc++;
                if (in_last || cur_n == NUM_DIGITS) begin
                    exp_q.push_back({4'(cur_n), cur_d});
                    cur_n = 0;
                    cur_d = '0;
                end
            end
        end
    end

    // Offers one pair and returns at posedge+1 after the accepting edge.
    // in_valid is left high so that consecutive calls hold it continuously.
    task automatic send(input logic [MUL_SIZE-1:0] a, input logic [MUL_SIZE-1:0] b, input logic last);
        bit acc;
        acc      = 0;
        in_a     = a;
        in_b     = b;
        in_last  = last;
        in_valid = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            if (in_ready) acc = 1;
            @(posedge clk);
            #1;
            if (acc) break;
            if (rnd_or) out_ready = 1'($urandom_range(0, 1));
        end
        if (!acc) check_val("send_timeout", 64'(0), 64'(1));
    endtask

    // Returns at the negedge where out_valid is first observed high.
    task automatic wait_out();
        bit seen;
        seen = 0;
        for (int t = 0; t < 100; t++) begin
            @(negedge clk);
            if (out_valid) begin
                seen = 1;
                break;
            end
        end
        if (!seen) check_val("out_timeout", 64'(0), 64'(1));
    endtask

    logic [MUL_SIZE-1:0] pa[4];
    logic [MUL_SIZE-1:0] pb[4];
    logic [15:0]         wd;

    initial begin
        pa[0] = 80'h8000_0000_0000_0000_0000;  pb[0] = 80'h8000_0000_0000_0000_0000; // 01
        pa[1] = {MUL_SIZE{1'b1}};              pb[1] = {MUL_SIZE{1'b1}};             // 11
        pa[2] = '0;                            pb[2] = 80'h1234_5678_9ABC_DEF0_1357; // 00
        pa[3] = 80'hC000_0000_0000_0000_0000;  pb[3] = 80'hC000_0000_0000_0000_0000; // 10

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check_val("rst_in_ready", 64'(in_ready), 64'(0));
        check_val("rst_mul_en", 64'(mul_en), 64'(0));
        check_val("rst_out_valid", 64'(out_valid), 64'(0));
        check_val("rst_out_digits", 64'(out_digits), 64'(0));
        check_val("rst_out_len", 64'(out_len), 64'(0));
        check_val("rst_mul_a", 64'(mul_a), 64'(0));
        #2 rst = 1'b0;
        @(negedge clk);
        check_val("idle_in_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;

        // Full word, in_valid held continuously (spacing checked by the monitor).
        spacing_mode = 1;
        for (int i = 0; i < 8; i++) send(pa[i % 4], pb[i % 4], 1'b0);
        in_valid = 1'b0;
        wait_out();
        check_val("full_digits", 64'(out_digits), 64'h7272);
        check_val("full_len", 64'(out_len), 64'(8));
        spacing_mode = 0;
        @(posedge clk); #1;

        // Short word, then a fresh word that must restart at the top digit.
        send(pa[1], pb[1], 1'b0);
        send(pa[3], pb[3], 1'b0);
        send(pa[0], pb[0], 1'b1);
        in_valid = 1'b0;
        wait_out();
        check_val("short_digits", 64'(out_digits), 64'hE400);
        check_val("short_len", 64'(out_len), 64'(3));
        @(posedge clk); #1;
        send(pa[0], pb[0], 1'b1);
        in_valid = 1'b0;
        wait_out();
        check_val("restart_digits", 64'(out_digits), 64'h4000);
        check_val("restart_len", 64'(out_len), 64'(1));
        @(posedge clk); #1;

        // Backpressure with a pending pair.
        out_ready = 1'b0;
        send(pa[1], pb[1], 1'b1);
        in_a = pa[3]; in_b = pb[3]; in_last = 1'b1; in_valid = 1'b1;
        wait_out();
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check_val("bp_valid", 64'(out_valid), 64'(1));
            check_val("bp_digits", 64'(out_digits), 64'hC000);
            check_val("bp_len", 64'(out_len), 64'(1));
            check_val("bp_in_ready", 64'(in_ready), 64'(0));
            check_val("bp_mul_en", 64'(mul_en), 64'(0));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check_val("bp_after_valid", 64'(out_valid), 64'(0));
        check_val("bp_after_ready", 64'(in_ready), 64'(1));
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check_val("bp_pending_issue", 64'(mul_en), 64'(1));
        wait_out();
        check_val("bp_pending_digits", 64'(out_digits), 64'h8000);
        @(posedge clk); #1;

        // Async reset in the middle of WAIT.
        send(pa[1], pb[1], 1'b0);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        #3;
        in_valid = 1'b1;
        rst = 1'b1;
        #1;
        check_val("arst_out_valid", 64'(out_valid), 64'(0));
        check_val("arst_mul_en", 64'(mul_en), 64'(0));
        check_val("arst_in_ready", 64'(in_ready), 64'(0));
        in_valid = 1'b0;
        @(negedge clk); @(negedge clk);
        #2 rst = 1'b0;
        @(posedge clk); #1;
        send(pa[3], pb[3], 1'b1);
        in_valid = 1'b0;
        wait_out();
        check_val("arst_len", 64'(out_len), 64'(1));
        wd = out_digits;
        check_val("arst_top_digit", 64'(wd[15:14]), 64'(2'b10));
        check_val("arst_low_digits", 64'(wd[13:0]), 64'(0));
        @(posedge clk); #1;

        // Async reset while a word is being presented.
        out_ready = 1'b0;
        send(pa[0], pb[0], 1'b1);
        in_valid = 1'b0;
        wait_out();
        #2 rst = 1'b1;
        #1;
        check_val("arst_out_drop", 64'(out_valid), 64'(0));
        check_val("arst_out_len", 64'(out_len), 64'(0));
        @(negedge clk); @(negedge clk);
        out_ready = 1'b1;
        #2 rst = 1'b0;
        @(posedge clk); #1;

        // Randomized traffic with random backpressure and gaps.
        rnd_or = 1;
        for (int i = 0; i < 60; i++) begin
            logic [MUL_SIZE-1:0] a;
            logic [MUL_SIZE-1:0] b;
            int sel;
            sel = int'($urandom_range(0, 4));
            if (sel < 4) begin
                a = pa[sel]; b = pb[sel];
            end else begin
                a = rand_op(); b = rand_op();
            end
            if ($urandom_range(0, 1) == 1) begin
                a = rand_op(); b = rand_op();
            end
            send(a, b, (i == 59) || ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) begin
                    @(posedge clk); #1;
                    out_ready = 1'($urandom_range(0, 1));
                end
            end
        end
        in_valid = 1'b0;
        rnd_or = 0;
        out_ready = 1'b1;
        for (int t = 0; t < 300; t++) begin
            @(posedge clk); #1;
            if (exp_q.size() == 0 && !out_valid) break;
        end
        check_val("drain_queue", 64'(exp_q.size()), 64'(0));
        check_val("mul_en_per_pair", 64'(n_mul), 64'(n_acc));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
